// File: rtl/im_loader_pkg.sv
// Shared encodings for the instruction-memory loader: FSM states and the frame header byte.
package im_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_WRITE,
    ST_CSUM
  } ldr_state_e;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
endpackage

// File: rtl/im_loader_timeout.sv
// Idle watchdog: reloadable down counter that pulses o_expire once TIMEOUT idle cycles elapse.
module ldr_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_f,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)                      r_cnt <= RELOAD;
    else if (i_load)                 r_cnt <= RELOAD;
    else if (i_en && r_cnt != '0)    r_cnt <= r_cnt - CW'(1);
  end

  // A byte arriving on the last tolerated cycle still wins over expiry.
  assign o_expire = i_en & ~i_load & (r_cnt == '0);
endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader: assembles 32-bit words, writes them to instruction memory
// from address 0 and releases the core only after the frame checksum verifies.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 65536,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_f,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err,
  output logic [15:0]       word_cnt
);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  ldr_state_e        r_state;
  logic [15:0]       r_n;
  logic [1:0]        r_bsel;
  logic [7:0]        r_xor;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst_f;
  logic              r_ok;
  logic              r_err;
  logic [15:0]       r_word_cnt;

  logic        w_xfer;
  logic        w_tmo_en;
  logic        w_tmo_exp;
  logic [15:0] w_n_rx;
  logic        w_too_big;
  logic [15:0] w_cnt_nxt;

  assign rx_ready  = (r_state != ST_WRITE);
  assign busy      = (r_state != ST_IDLE);
  assign w_xfer    = rx_valid & rx_ready;
  assign w_tmo_en  = busy && (r_state != ST_WRITE);
  assign w_n_rx    = {r_n[15:8], rx_data};
  assign w_too_big = {1'b0, w_n_rx} > DEPTH_L;
  assign w_cnt_nxt = r_word_cnt + 16'd1;

  // Counter stays loaded while disarmed, so every armed state starts with a full budget.
  ldr_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_f   (rst_f),
    .i_load  (w_xfer | ~w_tmo_en),
    .i_en    (w_tmo_en),
    .o_expire(w_tmo_exp)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_bsel      <= '0;
      r_xor       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rst_f <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_tmo_exp) begin
        // Abort keeps already-written words and leaves the core held.
        r_err   <= 1'b1;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (w_xfer && rx_data == FRAME_HDR) begin
            r_state     <= ST_CNT_HI;
            r_ok        <= 1'b0;
            r_err       <= 1'b0;
            r_word_cnt  <= '0;
            r_addr      <= '0;
            r_xor       <= '0;
            r_cpu_rst_f <= 1'b0;
          end
          ST_CNT_HI: if (w_xfer) begin
            r_n[15:8] <= rx_data;
            r_state   <= ST_CNT_LO;
          end
          ST_CNT_LO: if (w_xfer) begin
            r_n[7:0] <= rx_data;
            r_bsel   <= '0;
            if (w_too_big) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else if (w_n_rx == 16'd0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: if (w_xfer) begin
            r_wdata <= {r_wdata[23:0], rx_data};
            r_xor   <= r_xor ^ rx_data;
            r_bsel  <= r_bsel + 2'd1;
            if (r_bsel == 2'd3) begin
              r_we    <= 1'b1;
              r_state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            r_addr     <= r_addr + ADDR_W'(1);
            r_word_cnt <= w_cnt_nxt;
            r_state    <= (w_cnt_nxt == r_n) ? ST_CSUM : ST_DATA;
          end
          ST_CSUM: if (w_xfer) begin
            if (rx_data == r_xor) begin
              r_ok        <= 1'b1;
              r_cpu_rst_f <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign im_we     = r_we;
  assign im_addr   = r_addr;
  assign im_wdata  = r_wdata;
  assign cpu_rst_f = r_cpu_rst_f;
  assign load_ok   = r_ok;
  assign load_err  = r_err;
  assign word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_im_loader.sv
// Randomized frame-level bench for im_loader; expected writes and status derived from frame rules.
module tb_im_loader;
  localparam int AW = 3;
  localparam int DP = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_f;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst_f;
  logic          busy;
  logic          load_ok;
  logic          load_err;
  logic [15:0]   word_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int ready_bad  = 0;
  logic [AW+31:0] wr_q[$];
  logic [31:0]    fw[$];

  im_loader #(.ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_f(rst_f), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_rst_f(cpu_rst_f),
    .busy(busy), .load_ok(load_ok), .load_err(load_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Capture every memory write; rx_ready must be low exactly when im_we is high.
  always @(negedge clk) begin
    if (rst_f === 1'b1) begin
      if (im_we === 1'b1) wr_q.push_back({im_addr, im_wdata});
      if (rx_ready === im_we) ready_bad++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin rx_valid = 1'b0; @(negedge clk); end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 8) begin @(negedge clk); t++; end
    if (t >= 8) begin
      vectors++; miscompares++;
      $display("FAIL send_byte: rx_ready=%b required 1 within 8 cycles", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int n, input bit good, input int maxgap,
                           input int mingap, input int garb, input bit use_fw);
    logic [7:0]     bq[$];
    logic [AW+31:0] exp_q[$];
    logic [7:0]     gpat[3];
    logic [7:0]     g;
    logic [7:0]     cs;
    logic [31:0]    w;
    logic [15:0]    n16;
    bit             ok;
    int             m;
    gpat = '{8'h00, 8'hFF, 8'h3C};
    cs   = 8'h00;
    n16  = 16'(n);
    for (int i = 0; i < garb; i++) begin
      g = (i < 3) ? gpat[i] : 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      bq.push_back(g);
    end
    bq.push_back(8'hA5);
    bq.push_back(n16[15:8]);
    bq.push_back(n16[7:0]);
    if (n <= DP) begin
      for (int i = 0; i < n; i++) begin
        w = use_fw ? fw[i] : $urandom;
        for (int k = 3; k >= 0; k--) begin
          bq.push_back(w[8*k +: 8]);
          cs = cs ^ w[8*k +: 8];
        end
        exp_q.push_back({AW'(i), w});
      end
      bq.push_back(good ? cs : (cs ^ 8'($urandom_range(255, 1))));
    end
    wr_q.delete();
    foreach (bq[i]) send_byte(bq[i], int'($urandom_range(maxgap, mingap)));
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    ok = (n <= DP) && good;
    vectors++;
    if (wr_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s write count: got %0d required %0d", tag, wr_q.size(), exp_q.size());
    end
    m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      vectors++;
      if (wr_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s write %0d addr/data: got %h required %h", tag, i, wr_q[i], exp_q[i]);
      end
    end
    vectors++;
    if ({load_ok, load_err, cpu_rst_f, busy} !== {ok, !ok, ok, 1'b0}) begin
      miscompares++;
      $display("FAIL %s ok/err/cpu_rst_f/busy: got %b required %b", tag,
               {load_ok, load_err, cpu_rst_f, busy}, {ok, !ok, ok, 1'b0});
    end
    vectors++;
    if (word_cnt !== ((n <= DP) ? n16 : 16'd0)) begin
      miscompares++;
      $display("FAIL %s word_cnt: got %0d required %0d", tag, word_cnt, (n <= DP) ? n : 0);
    end
    vectors++;
    if (im_addr !== ((n <= DP) ? AW'(n) : AW'(0))) begin
      miscompares++;
      $display("FAIL %s im_addr: got %0d required %0d", tag, im_addr, (n <= DP) ? (n % DP) : 0);
    end
  endtask

  task automatic test_reset();
    rst_f = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cpu_rst_f, im_we, im_addr, im_wdata, load_ok, load_err, word_cnt, busy, rx_ready} !==
        {1'b0, 1'b0, AW'(0), 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset values: got cpu=%b we=%b addr=%h wd=%h ok=%b err=%b cnt=%h busy=%b rdy=%b required 0/0/0/0/0/0/0/0/1",
               cpu_rst_f, im_we, im_addr, im_wdata, load_ok, load_err, word_cnt, busy, rx_ready);
    end
    rst_f = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_frame();
    fw.delete();
    fw.push_back(32'h12345678);
    fw.push_back(32'h9ABCDEF0);
    run_frame("spec_good", 2, 1'b1, 0, 0, 0, 1'b1);
    run_frame("spec_badcsum", 2, 1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_zero_len();
    run_frame("zero_good", 0, 1'b1, 1, 0, 0, 1'b0);
    run_frame("zero_bad", 0, 1'b0, 1, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    wr_q.delete();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rx_valid = 1'b0;
    repeat (TO - 3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout early abort: busy=%b required 1", busy);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if ({load_err, load_ok, busy, cpu_rst_f, 32'(wr_q.size())} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL timeout abort: got err=%b ok=%b busy=%b cpu=%b writes=%0d required 1/0/0/0/0",
               load_err, load_ok, busy, cpu_rst_f, wr_q.size());
    end
    run_frame("after_timeout_slow", 1, 1'b1, TO - 2, TO - 2, 0, 1'b0);
  endtask

  task automatic test_garbage_stream();
    run_frame("garbage_then_frame", 1, 1'b1, 0, 0, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rx_valid = 1'b0;
    rst_f = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cpu_rst_f, im_we, im_addr, im_wdata, load_ok, load_err, word_cnt, busy, rx_ready} !==
        {1'b0, 1'b0, AW'(0), 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid values: got cpu=%b we=%b addr=%h wd=%h ok=%b err=%b cnt=%h busy=%b rdy=%b required 0/0/0/0/0/0/0/0/1",
               cpu_rst_f, im_we, im_addr, im_wdata, load_ok, load_err, word_cnt, busy, rx_ready);
    end
    rst_f = 1'b1;
    @(negedge clk);
    run_frame("after_reset_mid", 1, 1'b1, 1, 0, 0, 1'b0);
  endtask

  task automatic test_size_bounds();
    run_frame("oversize", DP + 1, 1'b1, 1, 0, 0, 1'b0);
    run_frame("oversize_hi", 256, 1'b1, 1, 0, 0, 1'b0);
    run_frame("full_depth_wrap", DP, 1'b1, 1, 0, 0, 1'b0);
  endtask

  task automatic test_rehold();
    run_frame("rehold_load", 1, 1'b1, 0, 0, 0, 1'b0);
    send_byte(8'hA5, 0);
    rx_valid = 1'b0;
    vectors++;
    if ({cpu_rst_f, busy, load_ok} !== 3'b010) begin
      miscompares++;
      $display("FAIL rehold on header: got cpu/busy/ok=%b required 010", {cpu_rst_f, busy, load_ok});
    end
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cpu_rst_f, busy, load_ok} !== 3'b101) begin
      miscompares++;
      $display("FAIL rehold release: got cpu/busy/ok=%b required 101", {cpu_rst_f, busy, load_ok});
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      run_frame($sformatf("random%0d", r), int'($urandom_range(DP + 1, 0)),
                1'($urandom_range(1, 0)), 3, 0, int'($urandom_range(2, 0)), 1'b0);
    end
  endtask

  task automatic test_ready_handshake();
    vectors++;
    if (ready_bad !== 0) begin
      miscompares++;
      $display("FAIL rx_ready vs WRITE: got %0d bad cycles required 0", ready_bad);
    end
  endtask

  initial begin
    test_reset();
    test_spec_frame();
    test_zero_len();
    test_timeout();
    test_garbage_stream();
    test_reset_mid();
    test_size_bounds();
    test_rehold();
    test_random();
    test_ready_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
